// File: rtl/mem_arbiter.sv
// Two-master (CPU / debug) round-robin arbiter and single-cycle sequencer for the
// shared MU0 memory bus. One access per grant; the owner sees a one-cycle ack.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_rnw,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              memrq,
    output logic              rnw
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e state_q, state_d;
    // owner/ptr encoding: 0 = CPU, 1 = debug
    logic owner_q, owner_d;
    logic ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic rnw_q, rnw_d;
    logic memrq_q, memrq_d;
    logic cpu_ack_q, cpu_ack_d;
    logic dbg_ack_q, dbg_ack_d;
    logic elig_cpu, elig_dbg, win;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rnw_d     = rnw_q;
        memrq_d   = 1'b0;
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;

        // The owner's req is still high at its closing edge and must not re-win.
        elig_cpu = cpu_req && !(state_q == StAccess && !owner_q);
        elig_dbg = dbg_req && !(state_q == StAccess && owner_q);
        win      = (elig_cpu && elig_dbg) ? ptr_q : elig_dbg;

        if (state_q == StAccess) begin
            if (rnw_q) begin
                rdata_d = data;
            end
            cpu_ack_d = !owner_q;
            dbg_ack_d = owner_q;
            ptr_d     = !owner_q;
        end

        if (elig_cpu || elig_dbg) begin
            state_d = StAccess;
            owner_d = win;
            memrq_d = 1'b1;
            addr_d  = win ? dbg_addr  : cpu_addr;
            wdata_d = win ? dbg_wdata : cpu_wdata;
            rnw_d   = win ? dbg_rnw   : cpu_rnw;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rnw_q     <= 1'b1;
            memrq_q   <= 1'b0;
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rnw_q     <= rnw_d;
            memrq_q   <= memrq_d;
            cpu_ack_q <= cpu_ack_d;
            dbg_ack_q <= dbg_ack_d;
        end
    end

    assign data      = (state_q == StAccess && !rnw_q) ? wdata_q : {DATA_W{1'bz}};
    assign addr      = addr_q;
    assign memrq     = memrq_q;
    assign rnw       = rnw_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = rdata_q;
    assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural MU0-style memory on the bus.
// A bench-side keeper drives 16'hA5A5 whenever memrq is low to expose stray drives.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_rnw, dbg_req, dbg_rnw;
    logic [11:0] cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_ack, dbg_ack;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic [11:0] addr;
    wire  [15:0] data;
    logic        memrq, rnw;

    logic [15:0] mem [0:4095];
    int checks;
    int failures;

    mem_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_rnw(dbg_rnw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .addr(addr), .data(data), .memrq(memrq), .rnw(rnw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write commits on the falling edge.
    assign data = (memrq && rnw) ? mem[addr] : 16'hzzzz;
    assign data = (!memrq) ? 16'hA5A5 : 16'hzzzz;
    always @(negedge clk) if (memrq && !rnw) mem[addr] <= data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        // only formats; each caller steps the counters itself
        $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (memrq !== 1'b0) begin failures++; chk("rst_memrq", 16'(memrq), 0); end
        checks++; if (rnw !== 1'b1) begin failures++; chk("rst_rnw", 16'(rnw), 1); end
        checks++; if (addr !== 12'h000) begin failures++; chk("rst_addr", 16'(addr), 0); end
        checks++; if ({cpu_ack, dbg_ack} !== 2'b00) begin
            failures++; chk("rst_acks", 16'({cpu_ack, dbg_ack}), 0); end
        checks++; if (cpu_rdata !== 16'h0000) begin failures++; chk("rst_rdata", cpu_rdata, 0); end
        checks++; if (data !== 16'hA5A5) begin failures++; chk("rst_data_z", data, 16'hA5A5); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h064;
        tick();
        checks++; if (memrq !== 1'b1) begin failures++; chk("rd_memrq", 16'(memrq), 1); end
        checks++; if (addr !== 12'h064) begin failures++; chk("rd_addr", 16'(addr), 16'h064); end
        checks++; if (data !== 16'h4444) begin failures++; chk("rd_bus", data, 16'h4444); end
        checks++; if (cpu_ack !== 1'b0) begin failures++; chk("rd_early_ack", 16'(cpu_ack), 0); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin failures++; chk("rd_ack", 16'(cpu_ack), 1); end
        checks++; if (cpu_rdata !== 16'h4444) begin failures++; chk("rd_rdata", cpu_rdata, 16'h4444); end
        checks++; if (dbg_ack !== 1'b0) begin failures++; chk("rd_dbg_ack", 16'(dbg_ack), 0); end
        checks++; if (memrq !== 1'b0) begin failures++; chk("rd_memrq_off", 16'(memrq), 0); end
        cpu_req = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin failures++; chk("rd_ack_pulse", 16'(cpu_ack), 0); end
    endtask

    task automatic test_dbg_write_cpu_read();
        dbg_req = 1'b1; dbg_rnw = 1'b0; dbg_addr = 12'h0A0; dbg_wdata = 16'hBEEF;
        tick();
        checks++; if (memrq !== 1'b1) begin failures++; chk("wr_memrq", 16'(memrq), 1); end
        checks++; if (rnw !== 1'b0) begin failures++; chk("wr_rnw", 16'(rnw), 0); end
        checks++; if (addr !== 12'h0A0) begin failures++; chk("wr_addr", 16'(addr), 16'h0A0); end
        checks++; if (data !== 16'hBEEF) begin failures++; chk("wr_bus", data, 16'hBEEF); end
        tick();
        checks++; if (dbg_ack !== 1'b1) begin failures++; chk("wr_ack", 16'(dbg_ack), 1); end
        checks++; if (cpu_ack !== 1'b0) begin failures++; chk("wr_cpu_ack", 16'(cpu_ack), 0); end
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h0A0;
        tick();
        checks++; if (addr !== 12'h0A0) begin failures++; chk("wr_rb_addr", 16'(addr), 16'h0A0); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin failures++; chk("wr_rb_ack", 16'(cpu_ack), 1); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin failures++; chk("wr_rb_rdata", cpu_rdata, 16'hBEEF); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h065;
        dbg_req = 1'b1; dbg_rnw = 1'b1; dbg_addr = 12'h066;
        tick();
        checks++; if (addr !== 12'h065) begin failures++; chk("b2b_first_addr", 16'(addr), 16'h065); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin failures++; chk("b2b_cpu_ack", 16'(cpu_ack), 1); end
        checks++; if (cpu_rdata !== 16'h2222) begin failures++; chk("b2b_cpu_rdata", cpu_rdata, 16'h2222); end
        checks++; if (memrq !== 1'b1) begin failures++; chk("b2b_memrq_cont", 16'(memrq), 1); end
        checks++; if (addr !== 12'h066) begin failures++; chk("b2b_second_addr", 16'(addr), 16'h066); end
        cpu_req = 1'b0;
        tick();
        checks++; if (dbg_ack !== 1'b1) begin failures++; chk("b2b_dbg_ack", 16'(dbg_ack), 1); end
        checks++; if (dbg_rdata !== 16'h1111) begin failures++; chk("b2b_dbg_rdata", dbg_rdata, 16'h1111); end
        checks++; if (memrq !== 1'b0) begin failures++; chk("b2b_memrq_end", 16'(memrq), 0); end
        dbg_req = 1'b0;
        tick();
        // CPU served last -> next tie goes to debug
        cpu_req = 1'b1; cpu_addr = 12'h064;
        tick();
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_addr = 12'h000;
        dbg_req = 1'b1; dbg_addr = 12'h001;
        tick();
        checks++; if (addr !== 12'h001) begin failures++; chk("tie_dbg_first", 16'(addr), 16'h001); end
        tick();
        checks++; if (dbg_ack !== 1'b1) begin failures++; chk("tie_dbg_ack", 16'(dbg_ack), 1); end
        checks++; if (dbg_rdata !== 16'h1001) begin failures++; chk("tie_dbg_rdata", dbg_rdata, 16'h1001); end
        checks++; if (addr !== 12'h000) begin failures++; chk("tie_cpu_second", 16'(addr), 16'h000); end
        dbg_req = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b1) begin failures++; chk("tie_cpu_ack", 16'(cpu_ack), 1); end
        checks++; if (cpu_rdata !== 16'h1000) begin failures++; chk("tie_cpu_rdata", cpu_rdata, 16'h1000); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_same_master();
        logic [15:0] exp;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({memrq, addr} !== {1'b1, 12'(i)}) begin
                failures++; chk("rep_grant", {3'b0, memrq, addr}, {4'h1, 12'(i)}); end
            tick();
            exp = 16'h1000 + 16'(i);
            checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== exp) begin
                failures++; chk("rep_ack_rdata", cpu_rdata, exp); end
            checks++; if (memrq !== 1'b0) begin failures++; chk("rep_gap", 16'(memrq), 0); end
            cpu_addr = 12'(i + 1);
            if (i == 2) cpu_req = 1'b0;
        end
        tick();
        checks++; if ({memrq, cpu_ack} !== 2'b00) begin
            failures++; chk("rep_done", 16'({memrq, cpu_ack}), 0); end
    endtask

    task automatic test_reset_mid_access();
        dbg_req = 1'b1; dbg_rnw = 1'b0; dbg_addr = 12'h0B0; dbg_wdata = 16'h1234;
        tick();
        checks++; if ({memrq, rnw} !== 2'b10) begin failures++; chk("rm_write", 16'({memrq, rnw}), 2); end
        #5;
        reset = 1'b1;
        tick();
        checks++; if (dbg_ack !== 1'b0) begin failures++; chk("rm_no_ack", 16'(dbg_ack), 0); end
        checks++; if (memrq !== 1'b0) begin failures++; chk("rm_memrq", 16'(memrq), 0); end
        checks++; if (rnw !== 1'b1) begin failures++; chk("rm_rnw", 16'(rnw), 1); end
        checks++; if (data !== 16'hA5A5) begin failures++; chk("rm_data_z", data, 16'hA5A5); end
        dbg_req = 1'b0;
        reset = 1'b0;
        tick();
        checks++; if (dbg_ack !== 1'b0) begin failures++; chk("rm_no_late_ack", 16'(dbg_ack), 0); end
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h0B0;
        tick();
        tick();
        checks++; if (cpu_rdata !== 16'h1234 || cpu_ack !== 1'b1) begin
            failures++; chk("rm_readback", cpu_rdata, 16'h1234); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_field_stability();
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h064;
        tick();
        cpu_addr = 12'h065; cpu_rnw = 1'b0; cpu_wdata = 16'hDEAD;
        #1;
        checks++; if (addr !== 12'h064 || rnw !== 1'b1) begin
            failures++; chk("fs_addr_held", 16'(addr), 16'h064); end
        tick();
        checks++; if (cpu_rdata !== 16'h4444 || cpu_ack !== 1'b1) begin
            failures++; chk("fs_rdata", cpu_rdata, 16'h4444); end
        cpu_req = 1'b0; cpu_rnw = 1'b1;
        checks++; if (mem[12'h065] !== 16'h2222) begin failures++; chk("fs_no_write", mem[12'h065], 16'h2222); end
        tick();
        // req dropped right after grant still completes
        dbg_req = 1'b1; dbg_rnw = 1'b1; dbg_addr = 12'h066;
        tick();
        dbg_req = 1'b0;
        tick();
        checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 16'h1111) begin
            failures++; chk("drop_ack", dbg_rdata, 16'h1111); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h064] = 16'h4444;
        mem[12'h065] = 16'h2222;
        mem[12'h066] = 16'h1111;
        mem[12'h000] = 16'h1000;
        mem[12'h001] = 16'h1001;
        mem[12'h002] = 16'h1002;
        cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_rnw = 1'b1; dbg_addr = '0; dbg_wdata = '0;
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_back_to_back();
        test_same_master();
        test_reset_mid_access();
        test_field_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
